// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one Memory + BusDriver among NREQ requesters.
// Ports: clock/reset_L, req/req_we/req_addr/req_wdata in; grant/done/rdata out;
//        mem_addr/mem_re/mem_we and drv_en/drv_data to Memory/BusDriver; bus_in from bus.
module mem_bus_arbiter #(
   parameter int NREQ = 4,
   parameter int AW   = 8,
   parameter int DW   = 8
) (
   input  logic               clock,
   input  logic               reset_L,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    grant,
   output logic [NREQ-1:0]    done,
   output logic [DW-1:0]      rdata,
   output logic [AW-1:0]      mem_addr,
   output logic               mem_re,
   output logic               mem_we,
   output logic               drv_en,
   output logic [DW-1:0]      drv_data,
   input  logic [DW-1:0]      bus_in
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      DONE
   } state_t;

   state_t state;
   state_t state_nx;

   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   logic [PW-1:0] ptr_nx;
   logic [PW-1:0] pick;
   logic          any_req;

   logic          lat_we;
   logic [AW-1:0] lat_addr;
   logic [DW-1:0] lat_wdata;
   logic [DW-1:0] rdata_q;

   logic [NREQ-1:0] win_oh;

   // Search ptr, ptr+1, ... with wrap; iterating from the far end
   // leaves the closest set bit as the final pick.
   always_comb begin
      int idx;
      any_req = 1'b0;
      pick    = ptr;
      idx     = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ)
            idx = idx - NREQ;
         if (req[idx]) begin
            any_req = 1'b1;
            pick    = PW'(idx);
         end
      end
   end

   // Explicit wrap so non-power-of-2 NREQ never reaches an unused index.
   assign ptr_nx = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;

   assign win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win;

   // State register
   always_ff @(posedge clock) begin
      if (!reset_L)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Latched transaction fields, pointer and read data
   always_ff @(posedge clock) begin
      if (!reset_L) begin
         ptr       <= '0;
         win       <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rdata_q   <= '0;
      end else begin
         if (state == IDLE && any_req) begin
            win       <= pick;
            lat_we    <= req_we[pick];
            lat_addr  <= req_addr[int'(pick)*AW +: AW];
            lat_wdata <= req_wdata[int'(pick)*DW +: DW];
         end
         if (state == ACCESS && !lat_we)
            rdata_q <= bus_in;
         if (state == DONE)
            ptr <= ptr_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = any_req ? SETUP : IDLE;
         SETUP:   state_nx = ACCESS;
         ACCESS:  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs decoded from state and latched fields only
   always_comb begin
      grant    = '0;
      done     = '0;
      mem_addr = '0;
      mem_re   = 1'b0;
      mem_we   = 1'b0;
      drv_en   = 1'b0;
      drv_data = '0;
      unique case (state)
         IDLE: begin
         end
         SETUP: begin
            grant    = win_oh;
            mem_addr = lat_addr;
            if (lat_we) begin
               drv_en   = 1'b1;
               drv_data = lat_wdata;
            end
         end
         ACCESS: begin
            grant    = win_oh;
            mem_addr = lat_addr;
            if (lat_we) begin
               drv_en   = 1'b1;
               drv_data = lat_wdata;
               mem_we   = 1'b1;
            end else begin
               mem_re   = 1'b1;
            end
         end
         DONE: begin
            grant    = win_oh;
            done     = win_oh;
            mem_addr = lat_addr;
         end
         default: begin
         end
      endcase
   end

   assign rdata = rdata_q;

endmodule
